// File: rtl/slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : slave_mem
// Purpose  : Responder end of the Master req/ack transaction interface.
//            Accepts one read/write at a time, inserts pWait_Cycles wait
//            states, then returns a one-cycle ack. Reads come from a local
//            register file; accesses outside the window flag oRange_Err.
// Revision : 1.0 - initial release
// ============================================================================
module slave_mem #(
  parameter logic [31:0] pBase_Addr     = 32'h0000_0000,
  parameter int          pDepth         = 16,
  parameter int          pWait_Cycles   = 2,
  parameter logic [31:0] pDefault_Rdata = 32'hDEAD_BEEF
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        slave_req,
  input  logic [31:0] slave_addr,
  input  logic        slave_cmd,
  input  logic [31:0] slave_wdata,
  output logic        slave_ack,
  output logic [31:0] slave_rdata,
  output logic        oBusy,
  output logic        oRange_Err
);

  localparam int         cIdxW  = (pDepth > 1) ? $clog2(pDepth) : 1;
  localparam logic [8:0] cWait  = 9'(pWait_Cycles);
  localparam logic [31:0] cDepth = 32'(pDepth);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [cIdxW-1:0]   idx_q;
  logic               cmd_q;
  logic [31:0]        wdata_q;
  logic               inr_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_q [pDepth];

  // Address decode on the live bus; only meaningful in IDLE when capturing.
  logic [31:0]        offset;
  logic [31:0]        word;
  logic               live_inr;
  logic [cIdxW-1:0]   live_idx;

  assign offset   = slave_addr - pBase_Addr;
  assign word     = offset >> 2;
  assign live_inr = (word < cDepth);
  assign live_idx = word[cIdxW-1:0];

  // With zero wait states ACK is entered on the capture edge itself, so the
  // operation must come from the live bus rather than the latched copy.
  logic               in_idle;
  logic [cIdxW-1:0]   op_idx;
  logic               op_cmd;
  logic [31:0]        op_wdata;
  logic               op_inr;
  logic               enter_ack;

  assign in_idle   = (state_q == ST_IDLE);
  assign op_idx    = in_idle ? live_idx    : idx_q;
  assign op_cmd    = in_idle ? slave_cmd   : cmd_q;
  assign op_wdata  = in_idle ? slave_wdata : wdata_q;
  assign op_inr    = in_idle ? live_inr    : inr_q;
  assign enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (slave_req) begin
          cnt_d   = 8'd0;
          state_d = (pWait_Cycles > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (({1'b0, cnt_q} + 9'd1) == cWait) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!slave_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request so later bus changes cannot affect it.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      idx_q   <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= 32'd0;
      inr_q   <= 1'b0;
    end else if (in_idle && slave_req) begin
      idx_q   <= live_idx;
      cmd_q   <= slave_cmd;
      wdata_q <= slave_wdata;
      inr_q   <= live_inr;
    end
  end

  // Register file commit, read data and range flag, all on the ACK entry edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < pDepth; i++) begin
        mem_q[i] <= 32'd0;
      end
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_ack) begin
      err_q <= !op_inr;
      if (op_cmd) begin
        if (op_inr) begin
          mem_q[op_idx] <= op_wdata;
        end
      end else begin
        rdata_q <= op_inr ? mem_q[op_idx] : pDefault_Rdata;
      end
    end
  end

  assign slave_ack   = (state_q == ST_ACK);
  assign oRange_Err  = (state_q == ST_ACK) && err_q;
  assign oBusy       = !in_idle;
  assign slave_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_mem
// Purpose  : Scoreboard bench for slave_mem. Two instances: index 0 has
//            zero wait states and a non-zero base, index 1 uses defaults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_mem;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        cmd   [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        busy  [2];
  logic        err   [2];

  always #5 iClk = ~iClk;

  slave_mem #(.pBase_Addr(32'h0000_1000), .pDepth(16), .pWait_Cycles(0),
              .pDefault_Rdata(32'hDEAD_BEEF)) u_dut0 (
    .iClk(iClk), .iRst(iRst), .slave_req(req[0]), .slave_addr(addr[0]),
    .slave_cmd(cmd[0]), .slave_wdata(wdata[0]), .slave_ack(ack[0]),
    .slave_rdata(rdata[0]), .oBusy(busy[0]), .oRange_Err(err[0]));

  slave_mem u_dut1 (
    .iClk(iClk), .iRst(iRst), .slave_req(req[1]), .slave_addr(addr[1]),
    .slave_cmd(cmd[1]), .slave_wdata(wdata[1]), .slave_ack(ack[1]),
    .slave_rdata(rdata[1]), .oBusy(busy[1]), .oRange_Err(err[1]));

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic        wr;
    logic        er;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] model_mem [2][16];
  logic        exp_busy [2];
  logic [31:0] last_rd  [2];
  logic        prev_ack [2];

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int unsigned pw_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic mon_check(input int d);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (ack[d]) begin
      if (!have) begin
        chk("ack_unexpected", d, 32'd1, 32'd0);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk("ack_latency", d, cyc, e.cyc);
        chk("range_err", d, {31'd0, err[d]}, {31'd0, e.er});
        if (!e.wr) last_rd[d] = e.rd;
      end
    end else begin
      if (have && cyc >= e.cyc) begin
        chk("ack_missing", d, 32'd0, 32'd1);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      chk("err_idle", d, {31'd0, err[d]}, 32'd0);
    end
    chk("rdata", d, rdata[d], last_rd[d]);
    chk("busy", d, {31'd0, busy[d]}, {31'd0, exp_busy[d]});
    chk("ack_pulse", d, {31'd0, ack[d] & prev_ack[d]}, 32'd0);
    prev_ack[d] = ack[d];
  endtask

  // Monitor: samples just after every rising edge and checks against the queues.
  always @(posedge iClk) begin
    #1;
    cyc = cyc + 1;
    if (iRst) begin
      q0.delete();
      q1.delete();
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
    end
    for (int d = 0; d < 2; d++) mon_check(d);
  end

  // One master transaction: push expectation, hold req to ack (+hold), release.
  task automatic txn(input int d, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input int hold);
    exp_t        e;
    logic [31:0] off;
    bit          inr;
    int          idx;
    off   = a - base_of(d);
    inr   = (off >> 2) < 32'd16;
    idx   = inr ? int'(off >> 2) : 0;
    e.cyc = cyc + 1 + pw_of(d);
    e.wr  = wr;
    e.er  = !inr;
    e.rd  = (!wr) ? (inr ? model_mem[d][idx] : 32'hDEAD_BEEF) : 32'h0;
    if (wr && inr) model_mem[d][idx] = wd;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    req[d] = 1'b1; addr[d] = a; cmd[d] = wr; wdata[d] = wd;
    exp_busy[d] = 1'b1;
    @(negedge iClk);
    // Bus garbage after capture must be ignored.
    addr[d] = $urandom; wdata[d] = $urandom; cmd[d] = 1'($urandom);
    for (int k = 0; k < 20 && !ack[d]; k++) @(negedge iClk);
    repeat (1 + hold) @(negedge iClk);
    req[d] = 1'b0;
    exp_busy[d] = 1'b0;
    @(negedge iClk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    iRst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = 32'd0; cmd[d] = 1'b0; wdata[d] = 32'd0;
      exp_busy[d] = 1'b0; last_rd[d] = 32'd0; prev_ack[d] = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[d][i] = 32'd0;
    end
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    // Directed: default build (base 0, two wait states).
    txn(1, 1'b1, 32'h0000_0008, 32'hCAFE_0001, 0);
    txn(1, 1'b0, 32'h0000_003C, 32'h0, 0);
    txn(1, 1'b0, 32'h0000_0008, 32'h0, 0);
    txn(1, 1'b0, 32'h0000_0040, 32'h0, 0);
    txn(1, 1'b1, 32'h0000_0040, 32'h55AA_55AA, 0);
    txn(1, 1'b0, 32'h0000_000B, 32'h0, 0);
    // Master lingers one cycle past ack, then re-requests two cycles later.
    txn(1, 1'b0, 32'h0000_0008, 32'h0, 1);
    idle(2);
    txn(1, 1'b1, 32'h0000_003C, 32'h0BAD_F00D, 0);
    txn(1, 1'b0, 32'h0000_003C, 32'h0, 0);

    // Directed: zero-wait build, back-to-back write/read, below-base access.
    txn(0, 1'b1, 32'h0000_1010, 32'hA5A5_0F0F, 0);
    txn(0, 1'b0, 32'h0000_1010, 32'h0, 0);
    txn(0, 1'b0, 32'h0000_0FFC, 32'h0, 0);
    txn(0, 1'b0, 32'h0000_103F, 32'h0, 0);

    // Reset in the middle of a write's wait phase.
    req[1] = 1'b1; addr[1] = 32'h0000_0004; cmd[1] = 1'b1; wdata[1] = 32'h1234_5678;
    exp_busy[1] = 1'b1;
    @(negedge iClk);
    iRst = 1'b1; req[1] = 1'b0;
    exp_busy[0] = 1'b0; exp_busy[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model_mem[d][i] = 32'd0;
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    txn(1, 1'b0, 32'h0000_0004, 32'h0, 0);
    txn(1, 1'b0, 32'h0000_0008, 32'h0, 0);
    txn(0, 1'b0, 32'h0000_1010, 32'h0, 0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      int          d;
      bit          wr;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (d == 1) a = 32'($urandom_range(0, 32'h5F));
      else        a = 32'h0000_1000 - 32'h20 + 32'($urandom_range(0, 32'h7F));
      txn(d, wr, a, $urandom, int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
